pipe_reg_elastic: RTL

Parametrised, stallable and flushable pipeline register chain that generalises the fixed per-stage pipeline registers of the pipelined RISC-V core. It carries one packed payload of `DATA_W` bits through `STAGES` register slots, each with its own valid bit. A valid/ready handshake on both sides lets the hazard unit stall or flush the chain. The core uses it between any two pipeline stages, and where extra buffering is needed, e.g. in front of a multi-cycle unit.

---
 rtl/pipe_reg_elastic_if.sv | 47 ++++
 rtl/pipe_reg_elastic.sv | 101 ++++++++++
 2 files changed

// File: rtl/pipe_reg_elastic_if.sv
// pipe_reg_elastic_if: handshake bundle for the elastic pipeline register chain.
//   flush      : discard every in-flight item at the next edge (producer side drives)
//   in_valid   : upstream offers in_data
//   in_data    : DATA_W payload from upstream
//   in_ready   : chain accepts in_data this cycle (combinational)
//   out_valid  : output slot holds a valid item
//   out_data   : payload of the output slot
//   out_ready  : downstream consumes this cycle
//   occupancy  : number of valid slots (registered)
// master = the hazard unit / pipeline stages around the chain, slave = the chain itself.
interface pipe_reg_elastic_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STAGES = 2
);
    localparam int unsigned CNT_W = $clog2(STAGES + 1);

    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [CNT_W-1:0]  occupancy;

    modport master (
        output flush,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  occupancy
    );

    modport slave (
        input  flush,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output occupancy
    );
endinterface

// File: rtl/pipe_reg_elastic.sv
// pipe_reg_elastic: stallable, flushable chain of STAGES register slots carrying a
// DATA_W payload, each slot with its own valid bit. Bubbles collapse while the
// output is stalled, so the chain fills completely before pushing back upstream.
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset (beats flush, which beats normal operation)
//   bus  : pipe_reg_elastic_if.slave (flush, in_valid/in_data/in_ready,
//          out_valid/out_data/out_ready, occupancy)
// in_ready and out_valid are combinational; out_ready and flush reach in_ready
// through a ripple whose depth grows with STAGES.
module pipe_reg_elastic #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STAGES = 2
) (
    input logic               clk,
    input logic               rst,
    pipe_reg_elastic_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(STAGES + 1);
    localparam int unsigned LAST  = STAGES - 1;

    logic [STAGES-1:0] r_v;
    logic [DATA_W-1:0] r_d [STAGES];
    logic [CNT_W-1:0]  r_occ;

    logic [STAGES-1:0] w_take;
    logic [STAGES-1:0] w_adv;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_in_xfer;
    logic              w_out_xfer;

    // Advance terms ripple from the output slot back to the input slot:
    // a slot can take a new item if it is empty or its own item moves on.
    always_comb begin
        w_take      = '0;
        w_adv       = '0;
        w_adv[LAST]  = r_v[LAST] && bus.out_ready && !bus.flush;
        w_take[LAST] = !r_v[LAST] || w_adv[LAST];
        for (int i = int'(LAST) - 1; i >= 0; i--) begin
            w_adv[i]  = r_v[i] && w_take[i+1];
            w_take[i] = !r_v[i] || w_adv[i];
        end
    end

    // Handshake terms; flush blocks both transfers in its cycle.
    always_comb begin
        w_in_ready  = w_take[0] && !bus.flush;
        w_out_valid = r_v[LAST] && !bus.flush;
        w_in_xfer   = bus.in_valid && w_in_ready;
        w_out_xfer  = w_out_valid && bus.out_ready;
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_d[LAST];
    assign bus.occupancy = r_occ;

    // Slot state and occupancy. Payload only changes when a slot loads; neither
    // advancing out of a slot nor flush touches it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v   <= '0;
            r_occ <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                r_d[i] <= '0;
            end
        end else if (bus.flush) begin
            r_v   <= '0;
            r_occ <= '0;
        end else begin
            if (w_in_xfer) begin
                r_v[0] <= 1'b1;
                r_d[0] <= bus.in_data;
            end else if (w_adv[0]) begin
                r_v[0] <= 1'b0;
            end

            for (int i = 1; i < int'(STAGES); i++) begin
                if (w_adv[i-1]) begin
                    r_v[i] <= 1'b1;
                    r_d[i] <= r_d[i-1];
                end else if (w_adv[i]) begin
                    r_v[i] <= 1'b0;
                end
            end

            if (w_in_xfer && !w_out_xfer) begin
                r_occ <= r_occ + CNT_W'(1);
            end else if (!w_in_xfer && w_out_xfer) begin
                r_occ <= r_occ - CNT_W'(1);
            end
        end
    end

    // The counter is a shortcut for popcount(r_v); they must never diverge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (CNT_W'($countones(r_v)) == r_occ);
        end
    end
endmodule
